// File: rtl/csr_wport_arbiter_if.sv
// Bundles the EX, trap-sequencer and csr_regs write-port signals of csr_wport_arbiter.
// slave is the arbiter's view; master is the view of whatever drives and observes it.
interface csr_wport_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ex_req_i;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0] ex_data_i;
  logic              ex_hold_o;
  logic              ex_flush_i;
  logic              int_req_i;
  logic              int_we_i;
  logic [ADDR_W-1:0] int_waddr_i;
  logic [DATA_W-1:0] int_data_i;
  logic              int_gnt_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] data_o;
  logic              hold_flag_o;
  logic              timeout_o;

  modport slave (
    input  ex_req_i, ex_waddr_i, ex_data_i, ex_flush_i,
    input  int_req_i, int_we_i, int_waddr_i, int_data_i,
    output ex_hold_o, int_gnt_o, we_o, waddr_o, data_o, hold_flag_o, timeout_o
  );

  modport master (
    output ex_req_i, ex_waddr_i, ex_data_i, ex_flush_i,
    output int_req_i, int_we_i, int_waddr_i, int_data_i,
    input  ex_hold_o, int_gnt_o, we_o, waddr_o, data_o, hold_flag_o, timeout_o
  );
endinterface

// File: rtl/csr_wport_arbiter.sv
// Arbitrates the single CSR write port between EX writes and locked trap-sequencer bursts,
// parking one colliding EX write for in-order replay and force-releasing over-long bursts.
module csr_wport_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 8
) (
  input logic                clk,
  input logic                rst,
  csr_wport_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INT,
    S_WAIT_REL
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_cnt_d;
  logic              lock_at_max;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic              busy;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              pend_load;
  logic              pend_clr;
  logic              ex_hold;
  logic              gnt_d;
  logic              timeout_d;

  assign lock_at_max = (lock_cnt == CNT_W'(MAX_LOCK - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.int_req_i) state_d = S_INT;
      end
      S_INT: begin
        if (!bus.int_req_i)  state_d = S_IDLE;
        else if (lock_at_max) state_d = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!bus.int_req_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // EX may only issue directly from an idle port with an empty buffer, which keeps program order.
  always_comb begin
    busy       = (state_q != S_IDLE) || bus.int_req_i;
    issue      = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    pend_load  = 1'b0;
    pend_clr   = 1'b0;
    ex_hold    = 1'b0;

    if (state_q == S_INT && bus.int_req_i && bus.int_we_i) begin
      issue      = 1'b1;
      issue_addr = bus.int_waddr_i;
      issue_data = bus.int_data_i;
    end

    if (bus.ex_flush_i) begin
      pend_clr = 1'b1;
    end else if (busy) begin
      if (bus.ex_req_i) begin
        if (pend_valid) ex_hold   = 1'b1;
        else            pend_load = 1'b1;
      end
    end else if (pend_valid) begin
      issue      = 1'b1;
      issue_addr = pend_addr;
      issue_data = pend_data;
      if (bus.ex_req_i) pend_load = 1'b1;
      else              pend_clr  = 1'b1;
    end else if (bus.ex_req_i) begin
      issue      = 1'b1;
      issue_addr = bus.ex_waddr_i;
      issue_data = bus.ex_data_i;
    end

    gnt_d     = (state_d == S_INT);
    timeout_d = (state_q == S_INT) && (state_d == S_WAIT_REL);

    lock_cnt_d = lock_cnt;
    if (state_q == S_IDLE) begin
      lock_cnt_d = '0;
    end else if (state_q == S_INT && !lock_at_max) begin
      lock_cnt_d = lock_cnt + 1'b1;
    end
  end

  assign bus.ex_hold_o   = ex_hold;
  assign bus.hold_flag_o = (state_q != S_IDLE) || pend_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt      <= '0;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      bus.we_o      <= 1'b0;
      bus.waddr_o   <= '0;
      bus.data_o    <= '0;
      bus.int_gnt_o <= 1'b0;
      bus.timeout_o <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_d;
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.ex_waddr_i;
        pend_data  <= bus.ex_data_i;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      bus.we_o      <= issue;
      bus.waddr_o   <= issue_addr;
      bus.data_o    <= issue_data;
      bus.int_gnt_o <= gnt_d;
      bus.timeout_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_csr_wport_arbiter.sv
// Scoreboard bench for csr_wport_arbiter: a session-level reference model predicts writes and
// control outputs; a separate monitor pops expected writes whenever the write port is sampled.
module tb_csr_wport_arbiter;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int MAX_LOCK = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  csr_wport_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  csr_wport_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t exp_q[$];
  wr_t pend_q[$];
  bit  m_session   = 1'b0;
  int  m_gcnt      = 0;
  bit  exp_gnt     = 1'b0;
  bit  exp_timeout = 1'b0;
  bit  exp_valid   = 1'b0;
  bit  mon_en      = 1'b0;
  bit  last_hold   = 1'b0;
  int  errors      = 0;
  int  checks      = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The model thinks in trap sessions: a session opens on a request seen while the port is free,
  // grants for at most MAX_LOCK cycles, and closes when the request drops.
  task automatic applyStimulus(input bit rst_v, input bit ex_req, input logic [ADDR_W-1:0] ex_a,
                               input logic [DATA_W-1:0] ex_d, input bit flush, input bit int_req,
                               input bit int_we, input logic [ADDR_W-1:0] int_a,
                               input logic [DATA_W-1:0] int_d);
    bit  busy;
    bit  granted;
    bit  exp_hold;
    wr_t w;
    @(negedge clk);
    if (exp_valid) begin
      checkOutput("int_gnt", bus.int_gnt_o, exp_gnt);
      checkOutput("timeout", bus.timeout_o, exp_timeout);
    end
    rst             = rst_v;
    bus.ex_req_i    = ex_req;
    bus.ex_waddr_i  = ex_a;
    bus.ex_data_i   = ex_d;
    bus.ex_flush_i  = flush;
    bus.int_req_i   = int_req;
    bus.int_we_i    = int_we;
    bus.int_waddr_i = int_a;
    bus.int_data_i  = int_d;
    #1;
    busy     = m_session || int_req;
    granted  = m_session && (m_gcnt < MAX_LOCK);
    exp_hold = ex_req && !flush && busy && (pend_q.size() != 0);
    if (exp_valid) begin
      checkOutput("hold_flag", bus.hold_flag_o, m_session || (pend_q.size() != 0));
      checkOutput("ex_hold", bus.ex_hold_o, exp_hold);
    end
    last_hold = exp_hold;

    if (!rst_v) begin
      m_session   = 1'b0;
      m_gcnt      = 0;
      pend_q.delete();
      exp_gnt     = 1'b0;
      exp_timeout = 1'b0;
      exp_valid   = 1'b1;
      mon_en      = 1'b1;
    end else begin
      exp_timeout = 1'b0;
      if (m_session) begin
        if (!int_req) begin
          m_session = 1'b0;
        end else if (granted) begin
          if (int_we) begin
            w.addr = int_a;
            w.data = int_d;
            exp_q.push_back(w);
          end
          m_gcnt++;
          if (m_gcnt == MAX_LOCK) exp_timeout = 1'b1;
        end
      end else if (int_req) begin
        m_session = 1'b1;
        m_gcnt    = 0;
      end

      w.addr = ex_a;
      w.data = ex_d;
      if (flush) begin
        pend_q.delete();
      end else if (busy) begin
        if (ex_req && pend_q.size() == 0) pend_q.push_back(w);
      end else if (pend_q.size() != 0) begin
        exp_q.push_back(pend_q.pop_front());
        if (ex_req) pend_q.push_back(w);
      end else if (ex_req) begin
        exp_q.push_back(w);
      end
      exp_gnt = m_session && (m_gcnt < MAX_LOCK);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Every expected write is pushed one cycle before it must appear on the port.
  initial begin
    wr_t w;
    bit  exp_we;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        exp_we = (exp_q.size() != 0);
        checkOutput("we", bus.we_o, exp_we);
        if (exp_we) begin
          w = exp_q.pop_front();
          checkOutput("waddr", bus.waddr_o, w.addr);
          checkOutput("wdata", bus.data_o, w.data);
        end else begin
          checkOutput("idle_waddr", bus.waddr_o, 64'h0);
          checkOutput("idle_wdata", bus.data_o, 64'h0);
        end
      end
    end
  end

  initial begin
    bit               r_ex  = 1'b0;
    bit               r_int = 1'b0;
    bit               r_fl;
    bit               r_we;
    bit               r_rst;
    logic [ADDR_W-1:0] r_ea = '0;
    logic [DATA_W-1:0] r_ed = '0;
    logic [ADDR_W-1:0] r_ia;
    logic [DATA_W-1:0] r_id;

    bus.ex_req_i    = 1'b0;
    bus.ex_waddr_i  = '0;
    bus.ex_data_i   = '0;
    bus.ex_flush_i  = 1'b0;
    bus.int_req_i   = 1'b0;
    bus.int_we_i    = 1'b0;
    bus.int_waddr_i = '0;
    bus.int_data_i  = '0;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(1);

    $display("[TB] direct EX write");
    applyStimulus(1, 1, 64'h305, 64'h8000_0000, 0, 0, 0, 0, 0);
    idleCycles(2);

    $display("[TB] trap burst");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 64'h341, 64'h8000_0104);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 64'h300, 64'h1800);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 64'h342, 64'd11);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 64'h7ff, 64'hdead);
    idleCycles(2);

    $display("[TB] collision");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 64'h340, 64'h55, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 64'h341, 64'h66, 0, 1, 1, 64'h300, 64'h8);
    applyStimulus(1, 1, 64'h341, 64'h66, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 64'h341, 64'h66, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 64'h341, 64'h66, 0, 0, 0, 0, 0);
    idleCycles(3);

    $display("[TB] flush");
    applyStimulus(1, 1, 64'h343, 64'h77, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(3);

    $display("[TB] watchdog");
    for (int i = 0; i < 12; i++) begin
      r_ia = 64'h340 + 64'(i);
      r_id = {$urandom, $urandom};
      applyStimulus(1, 0, 0, 0, 0, 1, 1, r_ia, r_id);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 1, 64'h344, 64'h99, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 64'h341, 64'h1234);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 64'h342, 64'h5678);
    idleCycles(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_int = ~r_int;
      if (!last_hold) begin
        r_ex = ($urandom_range(0, 2) == 0);
        r_ea = 64'($urandom_range(0, 4095));
        r_ed = {$urandom, $urandom};
      end
      r_fl  = ($urandom_range(0, 19) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_ia  = 64'($urandom_range(0, 4095));
      r_id  = {$urandom, $urandom};
      r_rst = ($urandom_range(0, 199) != 0);
      applyStimulus(r_rst, r_ex, r_ea, r_ed, r_fl, r_int, r_we, r_ia, r_id);
    end
    idleCycles(4);

    @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
